// File: rtl/easy_onchip_memory_arbiter.sv
// easy_onchip_memory_arbiter
// Two Avalon-MM style masters sharing one single-port 32-bit on-chip RAM
// (1-cycle read latency). At most one access is granted per cycle; reads are
// returned with a per-master valid strobe, and out-of-range addresses are
// accepted but never reach the RAM, raising a sticky err_oor.
//
// Build option: EASY_ARB_ROUND_ROBIN_EN
//   defined   -> bounded-burst round-robin (MAX_BURST grants in a row while
//                the other master waits)
//   undefined -> fixed priority, m0 always wins contention
module easy_onchip_memory_arbiter #(
  parameter int DEPTH     = 5120,
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [12:0] m0_address,
  input  logic [3:0]  m0_byteenable,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,
  output logic        m0_readdatavalid,
  input  logic [12:0] m1_address,
  input  logic [3:0]  m1_byteenable,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,
  output logic        m1_readdatavalid,
  output logic [12:0] mem_address,
  output logic [3:0]  mem_byteenable,
  output logic [31:0] mem_writedata,
  output logic        mem_chipselect,
  output logic        mem_write,
  output logic        mem_clken,
  input  logic [31:0] mem_readdata,
  output logic        err_oor
);

  localparam logic [13:0] LP_DEPTH = 14'(DEPTH);

  logic        w_req0;
  logic        w_req1;
  logic        w_gnt_any;
  logic        w_gnt_sel;
  logic        w_sel;
  logic        w_gnt0;
  logic        w_gnt1;
  logic [12:0] w_addr;
  logic        w_sel_read;
  logic        w_sel_write;
  logic        w_oor;
  logic        w_cs;
  logic [31:0] w_rdata;

  logic        r_last;
  logic        r_rd_vld;
  logic        r_rd_who;
  logic        r_rd_oor;
  logic        r_err;
`ifdef EASY_ARB_ROUND_ROBIN_EN
  localparam logic [3:0] LP_MAX_BURST = 4'(MAX_BURST);
  logic [3:0]  r_cnt;
`endif

  assign w_req0 = m0_read | m0_write;
  assign w_req1 = m1_read | m1_write;

  // Grant decision from current requests and the burst history
  always_comb begin
    w_gnt_any = ~reset & (w_req0 | w_req1);
    w_gnt_sel = r_last;
    if (w_req0 & ~w_req1) begin
      w_gnt_sel = 1'b0;
    end else if (w_req1 & ~w_req0) begin
      w_gnt_sel = 1'b1;
    end else if (w_req0 & w_req1) begin
`ifdef EASY_ARB_ROUND_ROBIN_EN
      w_gnt_sel = (r_cnt < LP_MAX_BURST) ? r_last : ~r_last;
`else
      w_gnt_sel = 1'b0;
`endif
    end
  end

  // Without a grant the RAM-side fields park on the last granted master
  assign w_sel  = w_gnt_any ? w_gnt_sel : r_last;
  assign w_gnt0 = w_gnt_any & ~w_gnt_sel;
  assign w_gnt1 = w_gnt_any & w_gnt_sel;

  assign m0_waitrequest = reset | (w_req0 & ~w_gnt0);
  assign m1_waitrequest = reset | (w_req1 & ~w_gnt1);

  assign w_addr      = w_sel ? m1_address : m0_address;
  assign w_sel_read  = w_sel ? m1_read    : m0_read;
  assign w_sel_write = w_sel ? m1_write   : m0_write;
  assign w_oor       = {1'b0, w_addr} >= LP_DEPTH;
  assign w_cs        = w_gnt_any & ~w_oor;

  assign mem_address    = w_addr;
  assign mem_byteenable = w_sel ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = w_sel ? m1_writedata  : m0_writedata;
  assign mem_chipselect = w_cs;
  assign mem_write      = w_cs & w_sel_write;
  assign mem_clken      = ~reset;

  // Grant history, read-return pipeline and sticky range error
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last   <= 1'b0;
      r_rd_vld <= 1'b0;
      r_rd_who <= 1'b0;
      r_rd_oor <= 1'b0;
      r_err    <= 1'b0;
`ifdef EASY_ARB_ROUND_ROBIN_EN
      r_cnt    <= 4'd0;
`endif
    end else begin
      if (w_gnt_any) begin
        r_last <= w_sel;
      end
`ifdef EASY_ARB_ROUND_ROBIN_EN
      if (!w_gnt_any) begin
        r_cnt <= 4'd0;
      end else if (w_sel == r_last) begin
        r_cnt <= (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;
      end else begin
        r_cnt <= 4'd1;
      end
`endif
      // a simultaneous read+write is a write and returns nothing
      r_rd_vld <= w_gnt_any & w_sel_read & ~w_sel_write;
      r_rd_who <= w_sel;
      r_rd_oor <= w_oor;
      if (w_gnt_any & w_oor) begin
        r_err <= 1'b1;
      end
    end
  end

  // Outputs are forced quiet while reset is held so a strobe in flight is dropped
  assign w_rdata          = r_rd_oor ? 32'd0 : mem_readdata;
  assign m0_readdata      = w_rdata;
  assign m1_readdata      = w_rdata;
  assign m0_readdatavalid = ~reset & r_rd_vld & ~r_rd_who;
  assign m1_readdatavalid = ~reset & r_rd_vld & r_rd_who;
  assign err_oor          = ~reset & r_err;

endmodule

// File: tb/tb_easy_onchip_memory_arbiter.sv
// Bench for easy_onchip_memory_arbiter: transaction-level model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_easy_onchip_memory_arbiter;

  localparam int DEPTH     = 5120;
  localparam int MAX_BURST = 2;
`ifdef EASY_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [12:0] m0_address = '0, m1_address = '0;
  logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
  logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [31:0] m0_writedata = '0, m1_writedata = '0;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [12:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_readdata;
  logic        err_oor;

  int checks = 0;
  int errors = 0;

  easy_onchip_memory_arbiter #(.DEPTH(DEPTH), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_writedata(mem_writedata), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_clken(mem_clken), .mem_readdata(mem_readdata),
    .err_oor(err_oor)
  );

  always #5 clk = ~clk;

  // RAM: registered address, unregistered q
  logic [31:0] ram [0:8191];
  logic [12:0] ram_aq = '0;
  always @(posedge clk) begin
    if (mem_clken) begin
      if (mem_chipselect && mem_write)
        for (int k = 0; k < 4; k++)
          if (mem_byteenable[k]) ram[mem_address][8*k +: 8] <= mem_writedata[8*k +: 8];
      ram_aq <= mem_address;
    end
  end
  assign mem_readdata = ram[ram_aq];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic [31:0] mdl_mem [0:8191];
  int          mdl_last = 0;
  int          mdl_run  = 0;
  bit          mdl_pend = 0;
  int          mdl_pwho = 0;
  logic [31:0] mdl_pdata = '0;
  bit          mdl_err  = 0;

  initial begin
    int          g;
    bit          r0, r1, rd, wr, inr;
    logic [12:0] a;
    logic [3:0]  be;
    logic [31:0] d;
    forever begin
      @(negedge clk);
      r0 = m0_read | m0_write;
      r1 = m1_read | m1_write;
      g = -1;
      if (!reset) begin
        if (r0 && !r1) g = 0;
        else if (r1 && !r0) g = 1;
        else if (r0 && r1) g = RR ? ((mdl_run < MAX_BURST) ? mdl_last : 1 - mdl_last) : 0;
      end
      a   = (g == 1) ? m1_address : m0_address;
      rd  = (g == 1) ? m1_read : m0_read;
      wr  = (g == 1) ? m1_write : m0_write;
      be  = (g == 1) ? m1_byteenable : m0_byteenable;
      d   = (g == 1) ? m1_writedata : m0_writedata;
      inr = int'(a) < DEPTH;

      chk("m0_waitrequest", m0_waitrequest, reset | (r0 && g != 0));
      chk("m1_waitrequest", m1_waitrequest, reset | (r1 && g != 1));
      chk("mem_chipselect", mem_chipselect, g >= 0 && inr);
      chk("mem_write", mem_write, g >= 0 && inr && wr);
      chk("mem_clken", mem_clken, !reset);
      if (g >= 0 && inr) begin
        chk("mem_address", mem_address, a);
        chk("mem_byteenable", mem_byteenable, be);
        if (wr) chk("mem_writedata", mem_writedata, d);
      end
      chk("m0_readdatavalid", m0_readdatavalid, mdl_pend && !reset && mdl_pwho == 0);
      chk("m1_readdatavalid", m1_readdatavalid, mdl_pend && !reset && mdl_pwho == 1);
      if (mdl_pend && !reset)
        chk("readdata", (mdl_pwho == 0) ? m0_readdata : m1_readdata, mdl_pdata);
      chk("err_oor", err_oor, mdl_err && !reset);

      @(posedge clk);
      if (reset) begin
        mdl_last = 0; mdl_run = 0; mdl_pend = 0; mdl_err = 0;
      end else if (g >= 0) begin
        mdl_run  = (g == mdl_last) ? ((mdl_run < 15) ? mdl_run + 1 : 15) : 1;
        mdl_last = g;
        mdl_pend = rd && !wr;
        mdl_pwho = g;
        mdl_pdata = inr ? mdl_mem[a] : 32'd0;
        if (!inr) mdl_err = 1;
        if (wr && inr)
          for (int k = 0; k < 4; k++)
            if (be[k]) mdl_mem[a][8*k +: 8] = d[8*k +: 8];
      end else begin
        mdl_run = 0; mdl_pend = 0;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drv(input int n, input logic rd, input logic wr, input logic [12:0] a,
                     input logic [3:0] be, input logic [31:0] d);
    if (n == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
    end
  endtask

  function automatic int granted();
    if ((m0_read | m0_write) && !m0_waitrequest) return 0;
    if ((m1_read | m1_write) && !m1_waitrequest) return 1;
    return -1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, time %0t expected below 200000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_seq [6];
    int wait0, wait1, max_wait;
    exp_seq = '{0, 0, 1, 1, 0, 0};

    // reset values
    @(negedge clk);
    chk("rst_m0_wait", m0_waitrequest, 1);
    chk("rst_m1_wait", m1_waitrequest, 1);
    chk("rst_clken", mem_clken, 0);
    chk("rst_cs", mem_chipselect, 0);
    chk("rst_err", err_oor, 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // write then read-back of the same word in consecutive cycles
    drv(0, 0, 1, 13'd5, 4'hF, 32'hDEADBEEF);
    @(negedge clk); chk("wr_nowait", m0_waitrequest, 0);
    tick();
    drv(0, 1, 0, 13'd5, 4'h0, 32'h0);
    @(negedge clk); chk("rd_nowait", m0_waitrequest, 0);
    chk("wr_no_rdv", m0_readdatavalid, 0);
    tick();
    drv(0, 0, 0, 13'd0, 4'h0, 32'h0);
    @(negedge clk);
    chk("rd_vld_m0", m0_readdatavalid, 1);
    chk("rd_data", m0_readdata, 32'hDEADBEEF);
    chk("rd_vld_m1_quiet", m1_readdatavalid, 0);
    tick();

    // byte-enable merge
    drv(0, 0, 1, 13'd7, 4'hF, 32'h11223344); tick();
    drv(0, 0, 1, 13'd7, 4'h1, 32'h000000AA); tick();
    drv(0, 1, 0, 13'd7, 4'h0, 32'h0); tick();
    drv(0, 0, 0, 13'd0, 4'h0, 32'h0);
    @(negedge clk);
    chk("be_vld", m0_readdatavalid, 1);
    chk("be_data", m0_readdata, 32'h112233AA);
    tick();
    tick();

    // contention
    drv(0, 1, 0, 13'd5, 4'h0, 32'h0);
    drv(1, 1, 0, 13'd7, 4'h0, 32'h0);
    if (RR) begin
      wait0 = 0; wait1 = 0; max_wait = 0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        chk("rr_seq", granted(), exp_seq[i]);
        wait0 = m0_waitrequest ? wait0 + 1 : 0;
        wait1 = m1_waitrequest ? wait1 + 1 : 0;
        if (wait0 > max_wait) max_wait = wait0;
        if (wait1 > max_wait) max_wait = wait1;
        tick();
      end
      drv(0, 0, 0, 13'd0, 4'h0, 32'h0);
      drv(1, 0, 0, 13'd0, 4'h0, 32'h0);
      chk("rr_max_wait", max_wait, 2);
    end else begin
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        chk("fp_grant", granted(), 0);
        chk("fp_m1_wait", m1_waitrequest, 1);
        tick();
      end
      drv(0, 0, 0, 13'd0, 4'h0, 32'h0);
      @(negedge clk);
      chk("fp_m1_grant", m1_waitrequest, 0);
      tick();
      drv(1, 0, 0, 13'd0, 4'h0, 32'h0);
    end
    tick();

    // out-of-range accesses from m1
    drv(1, 1, 0, 13'd5120, 4'h0, 32'h0);
    @(negedge clk);
    chk("oor_rd_accept", m1_waitrequest, 0);
    chk("oor_rd_cs", mem_chipselect, 0);
    tick();
    drv(1, 0, 1, 13'd8191, 4'hF, 32'hCAFEF00D);
    @(negedge clk);
    chk("oor_wr_accept", m1_waitrequest, 0);
    chk("oor_wr_cs", mem_chipselect, 0);
    chk("oor_rd_vld", m1_readdatavalid, 1);
    chk("oor_rd_data", m1_readdata, 32'h0);
    tick();
    drv(1, 0, 0, 13'd0, 4'h0, 32'h0);
    repeat (3) tick();
    @(negedge clk); chk("oor_err_sticky", err_oor, 1);
    tick();

    // reset right after a read grant drops the return strobe
    drv(0, 1, 0, 13'd5, 4'h0, 32'h0);
    @(negedge clk); chk("mid_rd_grant", m0_waitrequest, 0);
    tick();
    drv(0, 0, 0, 13'd0, 4'h0, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_no_rdv", m0_readdatavalid, 0);
    chk("mid_rst_wait", m0_waitrequest, 1);
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_err", err_oor, 0);
    chk("post_rst_no_rdv", m0_readdatavalid, 0);
    tick();
    drv(0, 1, 0, 13'd5, 4'h0, 32'h0);
    @(negedge clk); chk("post_rst_grant", m0_waitrequest, 0);
    tick();
    drv(0, 0, 0, 13'd0, 4'h0, 32'h0);
    @(negedge clk);
    chk("post_rst_rdv", m0_readdatavalid, 1);
    chk("post_rst_data", m0_readdata, 32'hDEADBEEF);
    tick();
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/easy_onchip_memory_arbiter.md
# easy_onchip_memory_arbiter

Two-master arbiter in front of the single-port 32-bit on-chip RAM (5120 words, 13-bit word address, byte enables, 1-cycle read latency). It sits between two Avalon-MM style requesters and the RAM's slave port. It grants one access per cycle with bounded-burst round-robin, returns read data with a per-master valid strobe, and traps out-of-range addresses.

## Interface
- DEPTH, 5120, number of valid RAM words; addresses >= DEPTH are out of range
- MAX_BURST, 4, max consecutive grants to one master while the other is requesting (1..15)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- mN_address  in  13  word address, master N (N = 0,1)
- mN_byteenable  in  4  byte lanes for writes
- mN_read / mN_write  in  1 each  request strobes, held until waitrequest low
- mN_writedata  in  32  write data
- mN_waitrequest  out  1  high = access not accepted this cycle
- mN_readdata  out  32  read data, qualified by readdatavalid
- mN_readdatavalid  out  1  one-cycle strobe, read data valid
- mem_address  out  13  to RAM
- mem_byteenable  out  4  to RAM
- mem_writedata  out  32  to RAM
- mem_chipselect / mem_write  out  1 each  to RAM (RAM writes when both high)
- mem_clken  out  1  RAM clock enable, = ~reset
- mem_readdata  in  32  RAM q, unregistered, valid the cycle after address
- err_oor  out  1  sticky, set on any out-of-range access

## Operation
- reqN = mN_read | mN_write; read and write together are treated as a write.
- Grant is combinational from the current requests and registered state: last (last granted master, reset 0) and cnt (4-bit consecutive-grant count, reset 0).
- Only one master requesting: that master is granted.
- Both requesting: grant last if cnt < MAX_BURST, else the other master.
- On grant to the same master as last: cnt <= cnt+1, saturating at 15. On grant to the other master: last <= it, cnt <= 1. Cycle with no grant: cnt <= 0, last unchanged.
- mN_waitrequest = reset | reqN & ~grantN. It is low when the master is idle.
- Granted in-range access: mem_chipselect = 1; mem_write = write; address, byteenable and writedata muxed from the granted master. Otherwise mem_chipselect = 0, and the muxed fields follow last.
- Granted out-of-range access (address >= DEPTH):
  - Accepted normally, but mem_chipselect = 0.
  - err_oor <= 1.
  - A read returns readdata = 0 with its valid strobe.
- Read return: registered rd_vld and rd_who, plus a rd_oor flag.
  - mN_readdatavalid = rd_vld & (rd_who == N).
  - mN_readdata = rd_oor ? 0 : mem_readdata, driven to both masters.

## Timing
- Reset values:
  - waitrequest = 1 while reset is high.
  - readdatavalid = 0, err_oor = 0, mem_chipselect = 0, mem_clken = 0.
  - last = 0, cnt = 0.
- Write: committed at the clock edge ending the grant cycle; 0 wait cycles when uncontended.
- Read: readdatavalid is high exactly 1 cycle after the grant cycle.
- Back-to-back grants are allowed every cycle, so reads are fully pipelined.
- Write then read of the same address in consecutive cycles returns the new data.
- Reset mid-operation: no grant occurs while reset is high, and a read strobe pending at the reset edge is dropped. Nothing is replayed afterwards.
- err_oor clears only on reset.

## Configuration
- EASY_ARB_ROUND_ROBIN_EN defined: bounded-burst round-robin as above.
- EASY_ARB_ROUND_ROBIN_EN undefined: fixed priority. m0 always wins contention and m1 is granted only when m0 is idle. MAX_BURST and cnt are unused, and last still tracks the last grant.

## Test plan
- m0 writes 0xDEADBEEF to addr 5 with be=0xF, then reads addr 5 the next cycle → m0_readdatavalid high 1 cycle after the read grant, readdata 0xDEADBEEF, m1 sees no valid strobe.
- Byte-enable write of 0x000000AA with be=0x1 over 0x11223344 → read returns 0x112233AA.
- RR_EN, MAX_BURST=2, both masters read continuously → grant sequence 0,0,1,1,0,0. Each readdatavalid arrives at its own master one cycle later, and each master waits at most 2 cycles.
- Macro undefined, both requesting for 10 cycles → m0 gets 10 grants and m1_waitrequest stays high. m1 is granted in the cycle after m0 drops its request.
- m1 reads addr 5120 and writes addr 8191 → both accepted, mem_chipselect stays 0, read returns 0, err_oor = 1 until reset.
- m0 read granted, reset high the next cycle → no readdatavalid, and all outputs reach their reset values. After reset, an uncontended read completes in 1 cycle.
